// File: rtl/c3lib_rst_release_seq.sv
// Staged reset release sequencer: immediate async assertion, ordered synchronous
// release of NUM_STAGES active-low resets, one stage per (dly_cfg+1) cycles.
//
// state | meaning
// HOLD  | all stages held in reset; waits for synced rst_n and no sw_rst_req
// WAIT  | release in progress; counting down the interval for stage idx
// DONE  | all stages released; waits for sw_rst_req
`default_nettype none

module c3lib_rst_release_seq #(
  parameter int NUM_STAGES = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst_req,
  input  logic [CNT_WIDTH-1:0]  dly_cfg,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  rst_done,
  output logic                  busy
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("c3lib_rst_release_seq: NUM_STAGES must be in 1..16");
  end
  if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
    $error("c3lib_rst_release_seq: SYNC_DEPTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_rst_n;
  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  dly_q;
  logic [IDX_W-1:0]      idx;

  // Deassertion synchronizer: asserts with rst_n, releases SYNC_DEPTH edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      dly_q       <= '0;
      idx         <= '0;
      stage_rst_n <= '0;
      rst_done    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (sync_rst_n && !sw_rst_req) begin
            state <= ST_WAIT;
            dly_q <= dly_cfg;
            cnt   <= dly_cfg;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (sw_rst_req) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            rst_done    <= 1'b0;
            busy        <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            stage_rst_n[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              rst_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
              cnt <= dly_q;
            end
          end
        end

        ST_DONE: begin
          if (sw_rst_req) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            rst_done    <= 1'b0;
            busy        <= 1'b0;
          end
        end

        default: begin
          state       <= ST_HOLD;
          cnt         <= '0;
          idx         <= '0;
          stage_rst_n <= '0;
          rst_done    <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
